seg_scan_ctrl: RTL and testbench

Time-multiplexing scanner for the Basys3 4-digit seven-segment display. Sits directly upstream of the anode controller. It generates the 2-bit digit-select count that the anode controller decodes, and presents the matching hex nibble, decimal point and blank flag to the cathode decoder. Holds a double-buffered 16-bit display value, so new values appear only at frame boundaries and never tear.

---
 rtl/seg_pkg.sv | 31 +++
 rtl/seg_scan_ctrl_if.sv | 30 +++
 rtl/seg_prescaler.sv | 38 +++
 rtl/seg_scan_ctrl.sv | 126 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
// Contents:
//   N_DIGITS     - number of display digits (4 on the Basys3)
//   digit_idx_t  - digit select / scan counter type
//   nibble_t     - one hex digit
//   disp_val_t   - full four-digit display value
//   lz_hidden()  - leading-zero suppression test for one digit
package seg_pkg;

  localparam int N_DIGITS = 4;

  typedef logic [1:0]  digit_idx_t;
  typedef logic [3:0]  nibble_t;
  typedef logic [15:0] disp_val_t;

  // A digit k > 0 is hidden when it and every digit to its left are zero
  // and its own decimal point is off. Digit 0 is always shown, so an
  // all-zero value still displays a single "0".
  function automatic logic lz_hidden(disp_val_t v, logic [N_DIGITS-1:0] dpv,
                                     digit_idx_t k);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if ((i >= int'(k)) && (v[4*i +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
    return (k != 2'd0) && upper_zero && !dpv[k];
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Bus between the display producer and the scan controller.
// Producer side : load (1-cycle capture strobe), value (4 hex nibbles),
//                 dp_in (per-digit decimal points).
// Display side  : counter (digit index for the anode controller), nibble,
//                 dp, blank (to the cathode decoder), frame_start, pending.
// master = producer / observer, slave = scan controller.
interface seg_scan_ctrl_if;
  import seg_pkg::*;

  logic                load;
  disp_val_t           value;
  logic [N_DIGITS-1:0] dp_in;
  digit_idx_t          counter;
  nibble_t             nibble;
  logic                dp;
  logic                blank;
  logic                frame_start;
  logic                pending;

  modport master (
    output load, value, dp_in,
    input  counter, nibble, dp, blank, frame_start, pending
  );

  modport slave (
    input  load, value, dp_in,
    output counter, nibble, dp, blank, frame_start, pending
  );

endinterface

// File: rtl/seg_prescaler.sv
// Digit-slot prescaler: counts 0..DIV-1 and wraps.
// Ports:
//   clk          - system clock
//   rst_n        - synchronous reset, active-low
//   tick_o       - high in the last cycle of each slot (count == DIV-1)
//   presc_next_o - value the count takes after the coming edge; lets the
//                  owner register flags that line up with the count itself
module seg_prescaler #(
  parameter int DIV = 100000,
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          tick_o,
  output logic [PW-1:0] presc_next_o
);

  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] count_q;
  logic [PW-1:0] count_d;

  always_comb begin
    tick_o  = (count_q == LAST);
    count_d = tick_o ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign presc_next_o = count_d;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexing scanner for a 4-digit seven-segment display.
// Steps a 2-bit digit index once per REFRESH_DIV cycles and presents the
// matching nibble, decimal point and blank flag, all registered so they
// describe the same digit as counter in the same cycle. Loaded values sit
// in a shadow buffer and are committed to the displayed (active) buffer
// only at the 3 -> 0 wrap, so a frame never shows a mix of two values.
// Ports:
//   clk   - system clock (100 MHz)
//   rst_n - synchronous reset, active-low
//   bus   - seg_scan_ctrl_if.slave: load/value/dp_in in;
//           counter/nibble/dp/blank/frame_start/pending out
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter bit LZ_BLANK     = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  seg_scan_ctrl_if.slave  bus
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] BLANK_LIM = PW'(BLANK_CYCLES);

  logic          tick;
  logic [PW-1:0] presc_d;

  seg_prescaler #(
    .DIV (REFRESH_DIV)
  ) u_presc (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_o       (tick),
    .presc_next_o (presc_d)
  );

  digit_idx_t          counter_q, counter_d;
  disp_val_t           shadow_val_q, shadow_val_d;
  logic [N_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  disp_val_t           active_val_q, active_val_d;
  logic [N_DIGITS-1:0] active_dp_q, active_dp_d;
  logic                pending_q, pending_d;
  nibble_t             nibble_q, nibble_d;
  logic                dp_q, dp_d;
  logic                blank_q, blank_d;
  logic                frame_start_q, frame_start_d;
  logic                commit;

  always_comb begin
    commit    = tick && (counter_q == 2'd3);
    counter_d = tick ? counter_q + 2'd1 : counter_q;

    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    if (bus.load) begin
      shadow_val_d = bus.value;
      shadow_dp_d  = bus.dp_in;
    end

    // A load landing on the commit edge bypasses the shadow so it is
    // visible in digit 0 of the very next frame without a pending phase.
    active_val_d = active_val_q;
    active_dp_d  = active_dp_q;
    if (commit) begin
      if (bus.load) begin
        active_val_d = bus.value;
        active_dp_d  = bus.dp_in;
      end else if (pending_q) begin
        active_val_d = shadow_val_q;
        active_dp_d  = shadow_dp_q;
      end
    end

    if (commit) begin
      pending_d = 1'b0;
    end else if (bus.load) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    // Outputs are computed from next-state values so, once registered,
    // they match counter and the prescaler count of the same cycle.
    nibble_d      = active_val_d[{counter_d, 2'b00} +: 4];
    dp_d          = active_dp_d[counter_d];
    blank_d       = (presc_d < BLANK_LIM) ||
                    (LZ_BLANK && lz_hidden(active_val_d, active_dp_d, counter_d));
    frame_start_d = commit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      counter_q     <= '0;
      shadow_val_q  <= '0;
      shadow_dp_q   <= '0;
      active_val_q  <= '0;
      active_dp_q   <= '0;
      pending_q     <= 1'b0;
      nibble_q      <= '0;
      dp_q          <= 1'b0;
      blank_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      counter_q     <= counter_d;
      shadow_val_q  <= shadow_val_d;
      shadow_dp_q   <= shadow_dp_d;
      active_val_q  <= active_val_d;
      active_dp_q   <= active_dp_d;
      pending_q     <= pending_d;
      nibble_q      <= nibble_d;
      dp_q          <= dp_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.counter     = counter_q;
  assign bus.nibble      = nibble_q;
  assign bus.dp          = dp_q;
  assign bus.blank       = blank_q;
  assign bus.frame_start = frame_start_q;
  assign bus.pending     = pending_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with REFRESH_DIV = 8, BLANK_CYCLES = 2,
// LZ_BLANK = 1. The expected display timeline is written as segments of
// constant displayed value / pending flag; each cycle of a segment becomes
// one scoreboard entry. A monitor compares one entry per cycle on negedge.
module tb_seg_scan_ctrl;
  import seg_pkg::*;

  localparam int DIV = 8;
  localparam int BLK = 2;

  logic clk;
  logic rst_n;
  int   cyc;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (BLK),
    .LZ_BLANK     (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    digit_idx_t cnt;
    nibble_t    nib;
    logic       dp;
    logic       bl;
    logic       fs;
    logic       pend;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Expected outputs for cycles c0..c1. base is the cycle whose state is
  // the reset state (prescaler 0, digit 0); val/dpv is what the display
  // should be showing and pend the expected pending flag.
  task automatic push_range(input int c0, input int c1, input int base,
                            input disp_val_t val, input logic [3:0] dpv,
                            input logic pend);
    for (int c = c0; c <= c1; c++) begin
      exp_t      e;
      int        t;
      int        k;
      disp_val_t sh;
      t      = c - base;
      k      = (t / DIV) % 4;
      sh     = val >> (4 * k);
      e.c    = c;
      e.cnt  = digit_idx_t'(k);
      e.nib  = sh[3:0];
      e.dp   = dpv[k];
      e.bl   = ((t % DIV) < BLK) || ((k > 0) && (sh == 16'h0) && !dpv[k]);
      e.fs   = (t > 0) && ((t % (4 * DIV)) == 0);
      e.pend = pend;
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].c <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_total++;
      if (e.c != cyc) begin
        $display("FAIL missed_cycle: expectation for cycle %0d seen at cycle %0d", e.c, cyc);
      end else if (bus.counter === e.cnt && bus.nibble === e.nib && bus.dp === e.dp &&
                   bus.blank === e.bl && bus.frame_start === e.fs &&
                   bus.pending === e.pend) begin
        n_pass++;
      end else begin
        $display("FAIL scan_c%0d: got cnt=%0d nib=%h dp=%b blank=%b fs=%b pend=%b, want cnt=%0d nib=%h dp=%b blank=%b fs=%b pend=%b",
                 cyc, bus.counter, bus.nibble, bus.dp, bus.blank, bus.frame_start,
                 bus.pending, e.cnt, e.nib, e.dp, e.bl, e.fs, e.pend);
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a load so that it is sampled on the edge that produces cycle e.
  task automatic load_at(input int e, input disp_val_t v, input logic [3:0] d);
    wait_cyc(e - 1);
    bus.load  = 1'b1;
    bus.value = v;
    bus.dp_in = d;
    wait_cyc(e);
    bus.load  = 1'b0;
    bus.value = 16'h0;
    bus.dp_in = 4'h0;
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.load  = 1'b0;
    bus.value = 16'h0;
    bus.dp_in = 4'h0;

    // Timeline: cycle 3 is the last reset edge, so frame position t = cyc-3.
    push_range(1,   1,   1,   16'h0000, 4'h0, 1'b0);  // reset held
    push_range(2,   2,   2,   16'h0000, 4'h0, 1'b0);
    push_range(3,   46,  3,   16'h0000, 4'h0, 1'b0);  // idle scan, all zero
    push_range(47,  66,  3,   16'h0000, 4'h0, 1'b1);  // 1234 waiting
    push_range(67,  98,  3,   16'h1234, 4'h0, 1'b0);  // 1234 committed
    push_range(99,  102, 3,   16'hABCD, 4'h0, 1'b0);  // load on commit edge
    push_range(103, 130, 3,   16'hABCD, 4'h0, 1'b1);  // 0070 waiting
    push_range(131, 132, 3,   16'h0070, 4'h0, 1'b0);  // leading zeros hidden
    push_range(133, 162, 3,   16'h0070, 4'h0, 1'b1);  // 0070 + dp3 waiting
    push_range(163, 172, 3,   16'h0070, 4'h8, 1'b0);  // digit 3 shown via dp
    push_range(173, 194, 3,   16'h0070, 4'h8, 1'b1);  // 1111 then 2222 waiting
    push_range(195, 232, 3,   16'h2222, 4'h0, 1'b0);  // only 2222 committed
    push_range(233, 244, 3,   16'h2222, 4'h0, 1'b1);  // FFFF waiting
    push_range(245, 245, 245, 16'h0000, 4'h0, 1'b0);  // reset mid-frame
    push_range(246, 320, 246, 16'h0000, 4'h0, 1'b0);  // FFFF discarded

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    load_at(47,  16'h1234, 4'h0);   // middle of digit 1
    load_at(99,  16'hABCD, 4'h0);   // exactly on the commit edge
    load_at(103, 16'h0070, 4'h0);
    load_at(133, 16'h0070, 4'h8);
    load_at(173, 16'h1111, 4'h0);
    load_at(183, 16'h2222, 4'h0);
    load_at(233, 16'hFFFF, 4'h0);

    wait_cyc(244);                  // digit 2, before commit
    rst_n = 1'b0;
    wait_cyc(246);
    rst_n = 1'b1;

    wait_cyc(322);
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
